// File: rtl/wb_burst_ram_slave.sv
// Wishbone RAM slave with programmable wait states, classic cycles and
// registered-feedback bursts (constant, linear, wrap-4/8/16).
module wb_burst_ram_slave #(
  parameter int aw          = 32,
  parameter int dw          = 32,
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [aw-1:0]   wb_adr_i,
  input  logic [dw-1:0]   wb_dat_i,
  input  logic [dw/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [dw-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o
);

  localparam int BW = dw / 8;
  localparam int SH = (BW > 1) ? $clog2(BW) : 0;
  localparam int IW = aw - SH;
  localparam int MW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [IW-1:0] MEM_LIMIT = IW'(MEM_WORDS);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [2:0]    WAIT_LOAD = 3'(WAIT_STATES);
  localparam logic [2:0]    CTI_CONST = 3'b001;
  localparam logic [2:0]    CTI_INCR  = 3'b010;
  localparam logic [2:0]    CTI_END   = 3'b111;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT        = 2'd1,
    CLASSIC_ACK = 2'd2,
    BURST       = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [2:0]    cnt_r, cnt_s;
  logic          ack_r, ack_s;
  logic          err_r, err_s;
  logic [dw-1:0] dat_r, dat_s;
  logic [dw-1:0] mem [MEM_WORDS];

  logic [IW-1:0] adr_idx_s;
  logic [IW-1:0] next_idx_s;
  logic [IW-1:0] rsp_idx_s;
  logic          rsp_en_s;
  logic          beat_done_s;
  logic          wr_en_s;
  logic          unused_adr_s;

  function automatic logic in_range(input logic [IW-1:0] idx);
    in_range = (idx < MEM_LIMIT);
  endfunction

  function automatic logic is_burst(input logic [2:0] cti);
    is_burst = (cti == CTI_CONST) || (cti == CTI_INCR);
  endfunction

  // Wrapping bursts only advance the low index bits; the block base is kept.
  function automatic logic [IW-1:0] burst_next(input logic [IW-1:0] idx,
                                               input logic [2:0]    cti,
                                               input logic [1:0]    bte);
    logic [IW-1:0] inc;
    logic [IW-1:0] mask;
    inc  = idx + IDX_ONE;
    mask = '0;
    case (bte)
      2'b01:   mask[1:0] = 2'b11;
      2'b10:   mask[2:0] = 3'b111;
      2'b11:   mask[3:0] = 4'b1111;
      default: mask = '1;
    endcase
    if (cti == CTI_INCR) begin
      burst_next = (idx & ~mask) | (inc & mask);
    end else begin
      burst_next = idx;
    end
  endfunction

  assign adr_idx_s    = wb_adr_i[aw-1:SH];
  assign next_idx_s   = burst_next(adr_idx_s, wb_cti_i, wb_bte_i);
  // A beat completes on the edge where the master still holds stb over our ack/err.
  assign beat_done_s  = wb_cyc_i & wb_stb_i & (ack_r | err_r);
  assign wr_en_s      = beat_done_s & ack_r & wb_we_i & in_range(adr_idx_s);
  assign unused_adr_s = ^wb_adr_i;

  // Next-state, wait counter and response-address selection.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    rsp_en_s  = 1'b0;
    rsp_idx_s = adr_idx_s;
    case (state_r)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          state_s = WAIT;
          cnt_s   = WAIT_LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (!wb_cyc_i) begin
          state_s = IDLE;
          cnt_s   = 3'd0;
        end else if (cnt_r != 3'd0) begin
          cnt_s = cnt_r - 3'd1;
        end else if (wb_stb_i) begin
          rsp_en_s = 1'b1;
          state_s  = is_burst(wb_cti_i) ? BURST : CLASSIC_ACK;
        end else begin
          state_s = WAIT;
        end
      end
      CLASSIC_ACK: begin
        state_s = IDLE;
      end
      BURST: begin
        if (!wb_cyc_i) begin
          state_s = IDLE;
        end else if (beat_done_s && (wb_cti_i == CTI_END)) begin
          state_s = IDLE;
        end else if (wb_stb_i) begin
          rsp_en_s = 1'b1;
          // After a completed beat the bus still shows the old address, so prefetch.
          if (beat_done_s) begin
            rsp_idx_s = next_idx_s;
          end else begin
            rsp_idx_s = adr_idx_s;
          end
        end else begin
          state_s = BURST;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 3'd0;
      end
    endcase
  end

  // Response generation: ack with data for in-range words, err with zero data otherwise.
  always_comb begin
    ack_s = 1'b0;
    err_s = 1'b0;
    dat_s = '0;
    if (rsp_en_s && in_range(rsp_idx_s)) begin
      ack_s = 1'b1;
      dat_s = mem[rsp_idx_s[MW-1:0]];
    end else if (rsp_en_s) begin
      err_s = 1'b1;
    end else begin
      ack_s = 1'b0;
    end
  end

  // FSM state and registered bus outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r <= IDLE;
      cnt_r   <= 3'd0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      dat_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ack_r   <= ack_s;
      err_r   <= err_s;
      dat_r   <= dat_s;
    end
  end

  // Byte-enabled storage write; contents are deliberately not reset.
  always_ff @(posedge wb_clk_i) begin
    if (wr_en_s) begin
      for (int b = 0; b < BW; b++) begin
        if (wb_sel_i[b]) begin
          mem[adr_idx_s[MW-1:0]][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
        end
      end
    end
  end

  assign wb_dat_o = dat_r;
  assign wb_ack_o = ack_r;
  assign wb_err_o = err_r;
  assign wb_rty_o = 1'b0;

endmodule

// File: doc/wb_burst_ram_slave.md
WB_BURST_RAM_SLAVE -- requirements
Module: wb_burst_ram_slave

Interface
REQ-001 SHALL have parameter aw, default 32, address width in bits.
REQ-002 SHALL have parameter dw, default 32, data width in bits (multiple of 8).
REQ-003 SHALL have parameter MEM_WORDS, default 256, number of dw-wide storage words.
REQ-004 SHALL have parameter WAIT_STATES, default 2, range 0..7, idle cycles before the first ack of each cycle.
REQ-005 SHALL have one clock and asynchronous, active-high reset; ports: wb_clk_i input 1 clock; wb_rst_i input 1 reset.
REQ-006 SHALL have ports: wb_adr_i input aw byte address; wb_dat_i input dw write data; wb_sel_i input dw/8 byte enables; wb_we_i input 1 write; wb_cyc_i input 1 cycle; wb_stb_i input 1 strobe; wb_cti_i input 3 cycle type; wb_bte_i input 2 burst type.
REQ-007 SHALL have ports: wb_dat_o output dw read data; wb_ack_o output 1 ack; wb_err_o output 1 error; wb_rty_o output 1 retry, constant 0.

Function
REQ-008 SHALL decode word index = wb_adr_i >> log2(dw/8); index >= MEM_WORDS is out-of-range.
REQ-009 SHALL implement FSM states IDLE, WAIT, CLASSIC_ACK, BURST; wb_ack_o, wb_err_o, wb_dat_o SHALL be registered.
REQ-010 SHALL leave IDLE on cyc&stb: WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES; WAIT_STATES=0 -> respond next cycle.
REQ-011 SHALL, in WAIT, decrement counter each cycle; at 0, assert response the following cycle (first response exactly WAIT_STATES+1 cycles after request sampled).
REQ-012 SHALL treat cti 000 or 111 on the first beat as classic: single-cycle ack (or err), then IDLE for at least one cycle before any further response.
REQ-013 SHALL treat cti 001 (constant) or 010 (incrementing) as a burst: after the first ack, ack every cycle stb is high, no further wait states.
REQ-014 SHALL deassert ack on the cycle after stb is sampled low mid-burst and resume ack one cycle after stb returns high, with no added wait states.
REQ-015 SHALL end a burst after acking a beat presented with cti=111, then return to IDLE.
REQ-016 SHALL compute the next burst address: cti 001 -> same; cti 010 with bte 00 -> +dw/8; bte 01/10/11 -> wrap within 4/8/16-beat aligned block, upper bits unchanged.
REQ-017 SHALL present on wb_dat_o in each read ack cycle mem[index of that beat's address]; burst read data SHALL be prefetched from the REQ-016 predicted address.
REQ-018 SHALL write, on each acked write beat, only the bytes enabled in wb_sel_i, using that beat's wb_adr_i and wb_dat_i.
REQ-019 SHALL assert wb_err_o instead of wb_ack_o for out-of-range beats, with no memory write and wb_dat_o=0; ack and err SHALL never be high together.
REQ-020 SHALL return to IDLE the cycle after wb_cyc_i is sampled low in any state, with no further response.
REQ-021 SHALL ignore wb_stb_i when wb_cyc_i is low.

Reset
REQ-022 SHALL, on wb_rst_i high (asynchronous, also mid-burst), force FSM to IDLE and wb_ack_o=0, wb_err_o=0, wb_dat_o=0, wait counter=0.
REQ-023 SHALL leave memory contents unchanged by reset; power-up contents undefined.
REQ-024 SHALL not respond until a request is sampled on a clock edge after wb_rst_i is deasserted.

Verification
REQ-025 Classic write 0x10=0xDEADBEEF sel=1111, then classic read 0x10, WAIT_STATES=2 -> each ack exactly 3 cycles after request, single-cycle pulse; read data 0xDEADBEEF.
REQ-026 Incrementing burst write 8 beats from 0x20, bte=00, cti=111 on last beat, then same burst read -> 8 back-to-back acks after initial latency; read data matches, ack low after beat 8.
REQ-027 Wrap-4 read burst starting 0x38 over words 0x30..0x3C preloaded 1,2,3,4 -> data order 3,4,1,2.
REQ-028 Byte-enable write 0x40=0x11223344 sel=0101 over prior 0xAABBCCDD -> read 0xAA22CC44.
REQ-029 Classic read at byte address MEM_WORDS*4 -> wb_err_o pulse, wb_ack_o low, memory unchanged.
REQ-030 Assert wb_rst_i during beat 3 of an 8-beat burst -> ack/err low same cycle, FSM IDLE; next classic read returns the 2 completed written words intact.
